// File: rtl/ckp_gen_pkg.sv
// ckp_gen_pkg: shared FSM state type, parameter defaults and cam-window width for the crank/cam generator.
package ckp_gen_pkg;
  typedef enum logic [1:0] {IDLE, TLO, THI, GAP} state_t;
  localparam int TEETH_DEF = 60;
  localparam int MISS_DEF = 2;
  localparam int PW_DEF = 24;
  localparam int CW = 8;
endpackage

// File: rtl/ckp_gen_cam.sv
// ckp_gen_cam: 720-degree phase tracking and registered cam window, fed with next-cycle tooth/rev so cam lines up with them.
module ckp_gen_cam
  import ckp_gen_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          idle,
  input  logic          rev,
  input  logic [CW-1:0] tooth,
  input  logic [CW-1:0] cam_on,
  input  logic [CW-1:0] cam_off,
  output logic          cam
);
  logic r_phase;
  logic w_phase, w_in;
  assign w_phase = r_phase ^ rev;
  assign w_in = (cam_on < cam_off) ? (tooth >= cam_on && tooth < cam_off) :
                (cam_on > cam_off) ? (tooth >= cam_on || tooth < cam_off) : 1'b0;
  always_ff @(posedge clk)
    if (rst) begin
      r_phase <= 1'b0;
      cam <= 1'b1;
    end else begin
      r_phase <= w_phase;
      cam <= idle | ~(w_phase & w_in);
    end
endmodule

// File: rtl/ckp_gen.sv
// ckp_gen: 60-2 style crank (VR) and cam signal generator with programmable tooth period.
// Optional period ramp (step, per_min, per_max) is enabled by defining CKP_GEN_RAMP_EN.
module ckp_gen
  import ckp_gen_pkg::*;
#(
  parameter int TEETH = TEETH_DEF,
  parameter int MISS = MISS_DEF,
  parameter int PW = PW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 per_we,
  input  logic [PW-1:0]        per,
  input  logic [CW-1:0]        cam_on,
  input  logic [CW-1:0]        cam_off,
`ifdef CKP_GEN_RAMP_EN
  input  logic signed [PW-1:0] step,
  input  logic [PW-1:0]        per_min,
  input  logic [PW-1:0]        per_max,
`endif
  output logic                 vr,
  output logic                 cam,
  output logic [CW-1:0]        tooth,
  output logic                 rev
);
  localparam int NW = PW + $clog2(MISS + 1) + 1;
  state_t r_state, w_state;
  logic [NW-1:0] r_cnt, w_cnt, w_lo, w_hi, w_gap;
  logic [PW-1:0] r_per, r_act, w_base, w_new;
  logic [CW-1:0] w_tooth;
  logic w_rev, w_entry, w_last;
  // A strobe coinciding with a tooth start wins over the stored shadow.
  assign w_base = per_we ? ((per < PW'(2)) ? PW'(2) : per) : r_per;
`ifdef CKP_GEN_RAMP_EN
  logic signed [PW+1:0] w_sum;
  assign w_sum = $signed({2'b00, w_base}) + $signed({{2{step[PW-1]}}, step});
  assign w_new = (w_sum < $signed({2'b00, per_min})) ? per_min :
                 (w_sum > $signed({2'b00, per_max})) ? per_max : w_sum[PW-1:0];
`else
  assign w_new = w_base;
`endif
  assign w_lo = NW'(r_act >> 1);
  assign w_hi = NW'(r_act) - w_lo;
  assign w_gap = NW'(MISS) * NW'(r_act);
  assign w_last = tooth == CW'(TEETH - MISS - 1);
  assign w_entry = (w_state == TLO) && (r_state != TLO);
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt + NW'(1);
    w_tooth = tooth;
    w_rev = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        w_state = en ? TLO : IDLE;
        w_rev = en;
      end
      TLO: if (r_cnt == w_lo - NW'(1)) begin
        w_cnt = '0;
        w_state = THI;
      end
      THI: if (r_cnt == w_hi - NW'(1)) begin
        w_cnt = '0;
        w_state = !en ? IDLE : w_last ? GAP : TLO;
        w_tooth = !en ? '0 : w_last ? tooth : tooth + CW'(1);
      end
      GAP: if (r_cnt == w_gap - NW'(1)) begin
        w_cnt = '0;
        w_tooth = '0;
        w_state = en ? TLO : IDLE;
        w_rev = en;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_per <= PW'(2);
      r_act <= PW'(2);
      vr <= 1'b0;
      tooth <= '0;
      rev <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_per <= w_entry ? w_new : w_base;
      r_act <= w_entry ? w_new : r_act;
      vr <= w_state == THI;
      tooth <= w_tooth;
      rev <= w_rev;
    end
  ckp_gen_cam u_cam (
    .clk    (clk),
    .rst    (rst),
    .idle   (w_state == IDLE),
    .rev    (w_rev),
    .tooth  (w_tooth),
    .cam_on (cam_on),
    .cam_off(cam_off),
    .cam    (cam)
  );
endmodule
